// File: rtl/uart_mem_loader.sv
// uart_mem_loader
// Boot-time loader that receives a framed image over a UART line (8N1, idle
// high), assembles little-endian 32-bit words and writes them through the
// CPU test top's external data-memory port. The CPU is held in reset until
// the whole image has been written.
//
// Frame: SYNC_BYTE, word count N (16 bit, LSB first), N x 4 data bytes.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   rx            in   UART serial input (asynchronous to clk)
//   cpu_reset     out  high until the load completes
//   Ext_MemWrite  out  one-cycle write strobe
//   Ext_WriteData out  32-bit word being written
//   Ext_DataAdr   out  32-bit byte address being written
//   load_done     out  sticky, image fully written
//   frame_err     out  sticky, UART framing error seen before completion
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        load_done,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_SYNC, L_LEN0, L_LEN1, L_DATA, L_WRITE, L_DONE, L_ERR} ld_state_t;

  // Synchronizer flops (reset to the idle-high line level)
  logic rx_meta_q, rx_sync_q;

  // RX front end
  rx_state_t        r_state_q, r_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             stop_bad;

  // Loader
  ld_state_t   l_state_q, l_state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] adr_q, adr_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        load_done_q, load_done_d;
  logic        frame_err_q, frame_err_d;

  // RX bit timing: sample mid-bit, start bit re-checked at half a bit to
  // reject glitches. stop_bad is combinational so the loader can raise
  // frame_err in the cycle right after the bad stop sample.
  always_comb begin
    r_state_d    = r_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    stop_bad     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          r_state_d = R_START;
          clk_cnt_d = '0;
        end
      end
      R_START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          r_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            r_state_d = R_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          r_state_d = R_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Loader next-state. The write strobe and its data/address are prepared
  // on the 4th byte so they are registered exactly while in L_WRITE.
  always_comb begin
    l_state_d   = l_state_q;
    count_d     = count_q;
    index_d     = index_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    mem_write_d = 1'b0;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = load_done_q;
    frame_err_d = frame_err_q;
    case (l_state_q)
      L_SYNC: begin
        if (byte_valid_q && byte_q == SYNC_BYTE) l_state_d = L_LEN0;
      end
      L_LEN0: begin
        if (byte_valid_q) begin
          count_d[7:0] = byte_q;
          l_state_d    = L_LEN1;
        end
      end
      L_LEN1: begin
        if (byte_valid_q) begin
          count_d[15:8] = byte_q;
          index_d       = '0;
          byte_idx_d    = '0;
          if (byte_q == 8'd0 && count_q[7:0] == 8'd0) begin
            l_state_d   = L_DONE;
            cpu_reset_d = 1'b0;
            load_done_d = 1'b1;
          end else begin
            l_state_d = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (byte_valid_q) begin
          if (byte_idx_q == 2'd3) begin
            l_state_d   = L_WRITE;
            byte_idx_d  = '0;
            mem_write_d = 1'b1;
            wdata_d     = {byte_q, word_q[23:0]};
            adr_d       = BASE_ADDR + {14'd0, index_q, 2'b00};
          end else begin
            word_d[8*byte_idx_q +: 8] = byte_q;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      L_WRITE: begin
        index_d = index_q + 16'd1;
        if ((index_q + 16'd1) == count_q) begin
          l_state_d   = L_DONE;
          cpu_reset_d = 1'b0;
          load_done_d = 1'b1;
        end else begin
          l_state_d = L_DATA;
        end
      end
      L_DONE: l_state_d = L_DONE;
      L_ERR:  l_state_d = L_ERR;
      default: l_state_d = L_SYNC;
    endcase
    // A framing error before completion locks the loader until reset
    if (stop_bad && l_state_q != L_DONE && l_state_q != L_ERR) begin
      l_state_d   = L_ERR;
      frame_err_d = 1'b1;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      r_state_q    <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      l_state_q    <= L_SYNC;
      count_q      <= '0;
      index_q      <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      mem_write_q  <= 1'b0;
      wdata_q      <= '0;
      adr_q        <= BASE_ADDR;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      r_state_q    <= r_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      l_state_q    <= l_state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      mem_write_q  <= mem_write_d;
      wdata_q      <= wdata_d;
      adr_q        <= adr_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cpu_reset     = cpu_reset_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = adr_q;
  assign load_done     = load_done_q;
  assign frame_err     = frame_err_q;

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Boot-time loader sitting directly upstream of the CPU test top. It receives a framed program/data image over a UART serial line, assembles little-endian 32-bit words, and drives the top's external data-memory write port (`Ext_MemWrite`, `Ext_WriteData`, `Ext_DataAdr`). While loading, it holds the CPU in reset. After the last word is written it releases the CPU reset.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word i is written to `BASE_ADDR + 4*i`.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  UART serial input, idle high, 8N1, asynchronous to `clk`.
- `cpu_reset`  out  1  drives top-level `reset`; high until load completes.
- `Ext_MemWrite`  out  1  one-cycle write strobe to data memory.
- `Ext_WriteData`  out  32  word to write; valid when `Ext_MemWrite`=1.
- `Ext_DataAdr`  out  32  byte address; valid when `Ext_MemWrite`=1.
- `load_done`  out  1  high once the image is fully written; sticky until `reset`.
- `frame_err`  out  1  high on a UART framing error; sticky until `reset`.

## Operation
- **RX front end**
  - `rx` passes through a 2-flop synchronizer.
  - RX states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START on a synchronized low.
  - In R_START, sample at `CLKS_PER_BIT/2`. If the sample is high (glitch), return to R_IDLE; otherwise go to R_DATA.
  - R_DATA takes 8 samples, each `CLKS_PER_BIT` apart, LSB first.
  - R_STOP samples one bit later. A high sample gives a one-cycle `byte_valid` pulse with the byte. A low sample raises an internal framing error and returns to R_IDLE.
- **Frame format**: `SYNC_BYTE`, then a 16-bit word count N (LSB byte first), then N×4 data bytes, each word LSB byte first.
- **Loader FSM states**: L_SYNC, L_LEN0, L_LEN1, L_DATA, L_WRITE, L_DONE, L_ERR.
  - L_SYNC: bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` → L_LEN0.
  - L_LEN0 captures count[7:0]. L_LEN1 captures count[15:8].
  - From L_LEN1: N=0 → L_DONE; otherwise → L_DATA with word index 0 and byte index 0.
  - L_DATA shifts each byte into `word[8*k +: 8]` for k = 0..3. On the 4th byte → L_WRITE.
  - In the L_DATA/L_WRITE phase, `SYNC_BYTE` values are ordinary data.
  - L_WRITE lasts exactly 1 cycle with `Ext_MemWrite`=1, `Ext_WriteData`=word, `Ext_DataAdr`=`BASE_ADDR` + 4×index (32-bit, wraps modulo 2^32).
  - From L_WRITE: increment the index. If index+1 == N → L_DONE; else → L_DATA.
  - L_DONE: `cpu_reset`=0, `load_done`=1. All further RX bytes are ignored.
  - A framing error in any state other than L_DONE → L_ERR.
  - L_ERR: `frame_err`=1, `cpu_reset` stays 1, no writes. Only `reset` exits L_ERR.
  - A framing error in L_DONE is ignored, and `frame_err` stays 0.
- **Count width**: 16 bits, max 65535 words. The index counter is 16 bits.
- **Reset mid-load** aborts immediately. No write occurs in the reset cycle. The loader returns to L_SYNC and RX returns to R_IDLE, and the partial word is discarded.

## Timing
- **Reset values**: `cpu_reset`=1, `Ext_MemWrite`=0, `Ext_WriteData`=0, `Ext_DataAdr`=`BASE_ADDR`, `load_done`=0, `frame_err`=0. Loader in L_SYNC, RX in R_IDLE.
- **Outputs**: all registered; no combinational path from `rx`.
- **Synchronizer**: 2 cycles of latency.
- **`byte_valid`**: asserted `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` (±1) cycles after the synchronized start edge.
- **Write strobe**: `Ext_MemWrite` is asserted in the cycle after the `byte_valid` of each word's 4th byte.
- **Write hold**: `Ext_WriteData`/`Ext_DataAdr` hold their last values when the strobe is low.
- **`cpu_reset` release**:
  - Falls, and `load_done` rises, in the cycle after the final write strobe.
  - For N=0, this happens in the cycle after the `byte_valid` of count[15:8].
- **Back-to-back bytes**: must be accepted with no gap between stop bit and next start bit; the write cycle always fits inside the next byte time.
- **`frame_err`**: rises in the cycle after the bad stop sample.

## Test plan
- **Nominal load**: `CLKS_PER_BIT`=8, `BASE_ADDR`=0x100; send A5 02 00 78 56 34 12 EF BE AD DE → two strobes: (0x100, 0x12345678) then (0x104, 0xDEADBEEF); `cpu_reset` falls one cycle after the 2nd strobe; `load_done`=1.
- **Zero length**: send A5 00 00 → no strobe; `cpu_reset`=0 and `load_done`=1 one cycle after the last byte.
- **Junk before sync and sync as data**: send 00 FF 3C A5 01 00 A5 A5 A5 A5 → exactly one strobe, data 0xA5A5A5A5 at `BASE_ADDR`.
- **Framing error**: send A5 01 00, then a byte with stop bit low → `frame_err`=1, `cpu_reset` stays 1, no strobe. Further valid bytes have no effect until `reset`.
- **Reset mid-load**: assert `reset` for 1 cycle after 2 data bytes, then send a fresh frame A5 01 00 44 33 22 11 → single strobe with 0x11223344 at `BASE_ADDR`; no stale bytes appear in it.
- **Start glitch**: drive `rx` low for `CLKS_PER_BIT/4` cycles in idle → no `byte_valid`, no state change, `frame_err`=0.
